pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipeline_hazard_ctrl                                         |
// | Description : Pipeline stall/flush controller for branch mispredicts,      |
// |               multicycle memory waits and load-use hazards.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_decode,
    input  logic [31:0]          inst_execute,
    input  logic                 br_mispredict,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 stall_fetch,
    output logic                 stall_decode,
    output logic                 stall_execute,
    output logic                 stall_memory,
    output logic                 bubble_execute,
    output logic                 flush_decode,
    output logic                 pc_redirect,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] C_TIMEOUT = TMR_W'(MEM_TIMEOUT);

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic w_stall_fetch, w_stall_decode, w_stall_execute, w_stall_memory;
    logic w_bubble_execute, w_flush_decode, w_pc_redirect, w_mem_timeout;

    logic [6:0] w_op_dec, w_op_ex;
    logic [4:0] w_rd_ex, w_rs1_dec, w_rs2_dec;
    logic       w_uses_rs2, w_load_use;
    logic       unused_inst_bits;

    assign w_op_dec  = inst_decode[6:0];
    assign w_rs1_dec = inst_decode[19:15];
    assign w_rs2_dec = inst_decode[24:20];
    assign w_op_ex   = inst_execute[6:0];
    assign w_rd_ex   = inst_execute[11:7];

    assign unused_inst_bits = ^{inst_decode[31:25], inst_decode[14:7], inst_execute[31:12]};

    // Only formats that actually read rs2 can create a hazard through it.
    assign w_uses_rs2 = (w_op_dec == C_OP_RTYPE) || (w_op_dec == C_OP_STORE) ||
                        (w_op_dec == C_OP_BRANCH);
    assign w_load_use = (w_op_ex == C_OP_LOAD) && (w_rd_ex != 5'd0) &&
                        ((w_rd_ex == w_rs1_dec) || (w_uses_rs2 && (w_rd_ex == w_rs2_dec)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        w_stall_fetch    = 1'b0;
        w_stall_decode   = 1'b0;
        w_stall_execute  = 1'b0;
        w_stall_memory   = 1'b0;
        w_bubble_execute = 1'b0;
        w_flush_decode   = 1'b0;
        w_pc_redirect    = 1'b0;
        w_mem_timeout    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (br_mispredict) begin
                    w_pc_redirect    = 1'b1;
                    w_flush_decode   = 1'b1;
                    w_bubble_execute = 1'b1;
                    state_d          = ST_FLUSH;
                end else if (mem_req && !mem_ack) begin
                    w_stall_fetch   = 1'b1;
                    w_stall_decode  = 1'b1;
                    w_stall_execute = 1'b1;
                    w_stall_memory  = 1'b1;
                    timer_d         = TMR_W'(1);
                    state_d         = ST_MEM_WAIT;
                end else if (w_load_use) begin
                    w_stall_fetch    = 1'b1;
                    w_stall_decode   = 1'b1;
                    w_bubble_execute = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Squashes the instruction the synchronous IMEM fetched from the wrong path.
                w_flush_decode = 1'b1;
                state_d        = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else if (timer_q == C_TIMEOUT) begin
                    w_mem_timeout = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_RUN;
                end else begin
                    w_stall_fetch   = 1'b1;
                    w_stall_decode  = 1'b1;
                    w_stall_execute = 1'b1;
                    w_stall_memory  = 1'b1;
                    timer_d         = timer_q + TMR_W'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // Gated by reset so every control output reads low while reset is held.
    assign stall_fetch    = w_stall_fetch    & rst;
    assign stall_decode   = w_stall_decode   & rst;
    assign stall_execute  = w_stall_execute  & rst;
    assign stall_memory   = w_stall_memory   & rst;
    assign bubble_execute = w_bubble_execute & rst;
    assign flush_decode   = w_flush_decode   & rst;
    assign pc_redirect    = w_pc_redirect    & rst;
    assign mem_timeout    = w_mem_timeout    & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (w_stall_fetch && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
            if (w_pc_redirect && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire
